// File: rtl/q_flop_driver_if.sv
// Bundles the source-side valid/ready word bus and the Q-module data/ack handshake.
// The driver uses the master view; the source and Q-module environment use the slave view.
interface q_flop_driver_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             q_data;
   logic             q_req;
   logic             q_ack;
   logic             q_out;

   modport master (
      input  in_valid, in_data, q_ack, q_out,
      output in_ready, q_data, q_req
   );

   modport slave (
      output in_valid, in_data, q_ack, q_out,
      input  in_ready, q_data, q_req
   );
endinterface

// File: rtl/q_flop_driver.sv
// Clocked initiator for a Q-module data/ack stage: serialises WIDTH-bit words LSB first,
// one 4-phase handshake per bit, and checks the stage's returned out against each bit.
module q_flop_driver #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   q_flop_driver_if.master        bus,
   input  logic                   err_clr,
   output logic                   busy,
   output logic                   done,
   output logic                   err_mismatch,
   output logic                   err_timeout
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_REQ,
      S_REL,
      S_ERR
   } state_e;

   state_e                 state_q, state_d;
   logic [WIDTH-1:0]       shift_q, shift_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   q_data_q, q_data_d;
   logic                   q_req_q, q_req_d;
   logic                   done_q, done_d;
   logic                   err_mismatch_q, err_mismatch_d;
   logic                   err_timeout_q, err_timeout_d;
   logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
   logic [SYNC_STAGES-1:0] out_sync_q, out_sync_d;

   logic ack_s;
   logic out_s;
   logic in_ready;
   logic last_bit;
   logic timed_out;

   assign ack_s     = ack_sync_q[SYNC_STAGES-1];
   assign out_s     = out_sync_q[SYNC_STAGES-1];
   assign in_ready  = (state_q == S_IDLE) & ~err_timeout_q;
   assign last_bit  = (idx_q == IDX_W'(WIDTH - 1));
   assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      // NOTE: every _d starts from its hold value so no path through the case leaves a
      // signal unassigned; that is what keeps this block free of inferred latches.
      state_d        = state_q;
      shift_d        = shift_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      q_data_d       = q_data_q;
      q_req_d        = q_req_q;
      done_d         = 1'b0;
      err_mismatch_d = err_mismatch_q;
      err_timeout_d  = err_timeout_q;
      ack_sync_d     = {ack_sync_q[SYNC_STAGES-2:0], bus.q_ack};
      out_sync_d     = {out_sync_q[SYNC_STAGES-2:0], bus.q_out};

      // Outside ERR the clear only affects the mismatch flag; a new mismatch below wins.
      if (err_clr && (state_q != S_ERR)) err_mismatch_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready) begin
               shift_d  = bus.in_data;
               idx_d    = '0;
               q_data_d = bus.in_data[0];
               state_d  = S_SETUP;
            end
         end
         S_SETUP: begin
            q_req_d = 1'b1;
            cnt_d   = '0;
            state_d = S_REQ;
         end
         S_REQ: begin
            if (ack_s) begin
               if (out_s != q_data_q) err_mismatch_d = 1'b1;
               q_req_d = 1'b0;
               cnt_d   = '0;
               state_d = S_REL;
            end else if (timed_out) begin
               q_req_d       = 1'b0;
               err_timeout_d = 1'b1;
               state_d       = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_REL: begin
            if (!ack_s) begin
               if (last_bit) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  shift_d  = shift_q >> 1;
                  idx_d    = idx_q + 1'b1;
                  q_data_d = shift_d[0];
                  state_d  = S_SETUP;
               end
            end else if (timed_out) begin
               err_timeout_d = 1'b1;
               state_d       = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ERR: begin
            q_req_d = 1'b0;
            // Leave only once the stage has released ack, so the next word starts clean.
            if (err_clr && !ack_s) begin
               err_mismatch_d = 1'b0;
               err_timeout_d  = 1'b0;
               state_d        = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the shift register is reset along with the control flops; it is a handful of
   // bits, and a known value keeps q_data defined the moment reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         shift_q        <= '0;
         idx_q          <= '0;
         cnt_q          <= '0;
         q_data_q       <= 1'b0;
         q_req_q        <= 1'b0;
         done_q         <= 1'b0;
         err_mismatch_q <= 1'b0;
         err_timeout_q  <= 1'b0;
         ack_sync_q     <= '0;
         out_sync_q     <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values.
         state_q        <= state_d;
         shift_q        <= shift_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         q_data_q       <= q_data_d;
         q_req_q        <= q_req_d;
         done_q         <= done_d;
         err_mismatch_q <= err_mismatch_d;
         err_timeout_q  <= err_timeout_d;
         ack_sync_q     <= ack_sync_d;
         out_sync_q     <= out_sync_d;
      end
   end

   assign bus.in_ready = in_ready;
   assign bus.q_data   = q_data_q;
   assign bus.q_req    = q_req_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign err_mismatch = err_mismatch_q;
   assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_q_flop_driver.sv
// Bench for q_flop_driver: a behavioural Q-flop responder captures every handshaken bit,
// and captured words are compared against the words the bench handed to the source side.
module tb_q_flop_driver;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic err_clr = 1'b0;
   logic busy, done, err_mismatch, err_timeout;

   q_flop_driver_if #(.WIDTH(WIDTH)) bus ();

   q_flop_driver #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2),
      .TIMEOUT     (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .err_clr      (err_clr),
      .busy         (busy),
      .done         (done),
      .err_mismatch (err_mismatch),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Responder knobs and what it saw.
   int   rsp_dr       = 3;
   int   rsp_df       = 3;
   bit   rsp_noack    = 1'b0;
   int   rsp_force_hs = -1;
   logic rsp_force_val = 1'b0;
   int   rsp_hs       = 0;
   bit   cap[$];

   // Reference model: the words handed over, in order.
   logic [7:0] exp_words[$];

   // Monitor counters.
   int   done_cnt     = 0;
   int   req_rise_cnt = 0;
   int   req_high_cnt = 0;
   int   ready_viol   = 0;
   logic req_prev     = 1'b0;

   // Behavioural Q-flop: ack rises rsp_dr cycles after req, falls rsp_df cycles after req drops.
   initial begin
      int phase = 0;
      int cnt   = 0;
      bus.q_ack = 1'b0;
      bus.q_out = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            bus.q_ack = 1'b0;
            phase = 0;
            cnt   = 0;
         end else begin
            case (phase)
               0: if (bus.q_req && !rsp_noack) begin cnt = 0; phase = 1; end
               1: begin
                  cnt = cnt + 1;
                  if (cnt >= rsp_dr) begin
                     bus.q_out = (rsp_hs == rsp_force_hs) ? rsp_force_val : bus.q_data;
                     cap.push_back(bus.q_data);
                     bus.q_ack = 1'b1;
                     phase = 2;
                  end
               end
               2: if (!bus.q_req) begin cnt = 0; phase = 3; end
               default: begin
                  cnt = cnt + 1;
                  if (cnt >= rsp_df) begin
                     bus.q_ack = 1'b0;
                     rsp_hs = rsp_hs + 1;
                     phase = 0;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (done) done_cnt++;
         if (bus.q_req && !req_prev) req_rise_cnt++;
         if (bus.q_req) req_high_cnt++;
         req_prev = bus.q_req;
         if (busy && bus.in_ready) ready_viol++;
      end
   end

   task automatic wait_ready(input string tag);
      int i = 0;
      while (!bus.in_ready && i < 300) begin
         @(negedge clk);
         i++;
      end
      check(tag, bus.in_ready, 1);
   endtask

   task automatic wait_idle(input string tag);
      int i = 0;
      do begin
         @(negedge clk);
         i++;
      end while (busy && i < 3000);
      check(tag, busy, 0);
      #2;
   endtask

   task automatic send_word(input logic [7:0] w);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      wait_ready("send ready");
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      exp_words.push_back(w);
   endtask

   task automatic check_stream(input string tag);
      check({tag, " nbits"}, cap.size(), exp_words.size() * 8);
      for (int w = 0; w < exp_words.size(); w++) begin
         logic [7:0] g;
         g = '0;
         for (int b = 0; b < 8; b++)
            if (w * 8 + b < cap.size()) g[b] = cap[w * 8 + b];
         check($sformatf("%s word%0d", tag, w), g, exp_words[w]);
      end
      cap.delete();
      exp_words.delete();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      int d0, r0, base;
      logic [7:0] w;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;

      // Reset state.
      #12;
      check("rst q_req", bus.q_req, 0);
      check("rst q_data", bus.q_data, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      check("rst err_mismatch", err_mismatch, 0);
      check("rst err_timeout", err_timeout, 0);
      check("rst in_ready", bus.in_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single word with a fixed-delay responder.
      d0 = done_cnt; r0 = req_rise_cnt;
      send_word(8'hA5);
      wait_idle("a5 idle");
      check_stream("a5");
      check("a5 req pulses", req_rise_cnt - r0, 8);
      check("a5 done pulses", done_cnt - d0, 1);
      check("a5 err_mismatch", err_mismatch, 0);
      check("a5 ready while busy", ready_viol, 0);

      // Back-to-back words with in_valid held high.
      d0 = done_cnt; r0 = req_rise_cnt;
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      wait_ready("b2b ready0");
      @(posedge clk);
      #1;
      exp_words.push_back(8'hFF);
      bus.in_data = 8'h00;
      @(negedge clk);
      wait_ready("b2b ready1");
      check("b2b accept on done", done, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      exp_words.push_back(8'h00);
      wait_idle("b2b idle");
      check_stream("b2b");
      check("b2b req pulses", req_rise_cnt - r0, 16);
      check("b2b done pulses", done_cnt - d0, 2);

      // Forced mismatch on bit 2 of 8'h07.
      d0 = done_cnt;
      base = rsp_hs;
      rsp_force_hs  = base + 2;
      rsp_force_val = 1'b0;
      send_word(8'h07);
      begin
         int i = 0;
         while (rsp_hs < base + 2 && i < 500) begin @(negedge clk); i++; end
      end
      check("mm before bit2", err_mismatch, 0);
      wait_idle("mm idle");
      check("mm flag", err_mismatch, 1);
      check("mm done pulses", done_cnt - d0, 1);
      check_stream("mm");
      rsp_force_hs = -1;
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("mm cleared", err_mismatch, 0);

      // in_valid pulsed while busy must not be consumed.
      d0 = done_cnt;
      send_word(8'hC3);
      repeat (5) @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h3C;
      check("busy in_ready", bus.in_ready, 0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      wait_idle("busy idle");
      check_stream("busy");
      check("busy done pulses", done_cnt - d0, 1);

      // Responder never acks: timeout, ERR, then clear.
      rsp_noack = 1'b1;
      req_high_cnt = 0;
      send_word(8'h96);
      begin
         int i = 0;
         while (!err_timeout && i < 100) begin @(negedge clk); i++; end
      end
      check("to flag", err_timeout, 1);
      check("to q_req", bus.q_req, 0);
      check("to req cycles", req_high_cnt, TIMEOUT);
      check("to in_ready", bus.in_ready, 0);
      repeat (3) @(negedge clk);
      check("to hold err", busy, 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("to clr busy", busy, 0);
      check("to clr in_ready", bus.in_ready, 1);
      check("to clr flag", err_timeout, 0);
      rsp_noack = 1'b0;
      cap.delete();
      exp_words.delete();

      // Reset mid-word at bit 4 with a pending mismatch flag.
      base = rsp_hs;
      rsp_force_hs  = base;
      rsp_force_val = 1'b0;
      send_word(8'h5B);
      begin
         int i = 0;
         while (!(rsp_hs >= base + 4 && bus.q_req) && i < 500) begin @(negedge clk); i++; end
      end
      check("mid q_req high", bus.q_req, 1);
      check("mid err_mismatch", err_mismatch, 1);
      d0 = done_cnt;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("mid rst q_req", bus.q_req, 0);
      check("mid rst q_data", bus.q_data, 0);
      check("mid rst busy", busy, 0);
      check("mid rst err_mismatch", err_mismatch, 0);
      check("mid rst done", done, 0);
      rsp_force_hs = -1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cap.delete();
      exp_words.delete();
      repeat (2) @(negedge clk);
      check("mid no done", done_cnt - d0, 0);
      send_word(8'h3C);
      wait_idle("post rst idle");
      check_stream("post rst");

      // Randomised words and responder delays.
      d0 = done_cnt;
      for (int n = 0; n < 12; n++) begin
         rsp_dr = $urandom_range(1, 5);
         rsp_df = $urandom_range(1, 5);
         w = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_word(w);
         wait_idle("rand idle");
      end
      check_stream("rand");
      check("rand done pulses", done_cnt - d0, 12);
      check("rand err_mismatch", err_mismatch, 0);
      check("rand err_timeout", err_timeout, 0);
      check("ready while busy", ready_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/q_flop_driver.md
Name: q_flop_driver

Overview:
- Clocked transmitter that drives a Q-flop style data/ack handshake: it takes WIDTH-bit words from a synchronous valid/ready source and presents them LSB first, one bit per 4-phase handshake, to a Q-module stage.
- It waits on the stage's asynchronous ack, checks the returned out value against each sent bit, and flags mismatches and timeouts.
- It sits at the boundary between the clocked domain and the Q-module pipeline, as the initiator end of the stage's data/ack interface.

Parameters:
- WIDTH, 8, word width in bits, >=1.
- SYNC_STAGES, 2, flop depth of the q_ack/q_out synchronizers, >=2.
- TIMEOUT, 255, max cycles spent in REQ or REL before a timeout error, >=1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- in_valid  input  1  source word valid.
- in_ready  output  1  driver accepts a word this cycle.
- in_data  input  WIDTH  word to transmit.
- err_clr  input  1  clears sticky errors; leaves ERR state.
- q_data  output  1  bit presented to the Q-module; registered.
- q_req  output  1  handshake request; registered.
- q_ack  input  1  asynchronous ack from the Q-module.
- q_out  input  1  asynchronous out from the Q-module; stable while q_ack=1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a word's last handshake completes.
- err_mismatch  output  1  sticky; a sampled out differed from q_data.
- err_timeout  output  1  sticky; handshake exceeded TIMEOUT.

Behaviour:
- Reset (rst=0, asynchronous):
  - q_data=0, q_req=0, done=0, err_mismatch=0, err_timeout=0, busy=0.
  - state=IDLE, synchronizers cleared to 0.
- Synchronizers: q_ack and q_out each pass through SYNC_STAGES flops, giving ack_s and out_s. Only ack_s and out_s are used internally.
- Combinational outputs:
  - in_ready = (state==IDLE) & ~err_timeout.
  - busy = (state!=IDLE).
- States: IDLE, SETUP, REQ, REL, ERR.
- IDLE:
  - On in_valid & in_ready, latch in_data into the shift register, set bit index=0, drive q_data=in_data[0], go to SETUP.
  - in_valid while not ready is ignored; the word is not consumed.
- SETUP:
  - Exactly 1 cycle, so data is set up before the request.
  - Then q_req<=1, clear the timeout counter, go to REQ.
- REQ:
  - Wait for ack_s=1.
  - On ack_s=1: compare out_s with q_data; on mismatch set err_mismatch (transfer continues). Then q_req<=0, clear the counter, go to REL.
- REL:
  - Wait for ack_s=0.
  - If bit index==WIDTH-1: done<=1 for one cycle, go to IDLE.
  - Otherwise: shift, increment index, drive the next bit on q_data, go to SETUP.
  - q_data holds its value through REQ and REL; it changes only on entry to SETUP.
- Timeout:
  - The counter increments each cycle in REQ or REL.
  - When it reaches TIMEOUT: q_req<=0, err_timeout<=1, go to ERR. The remaining word bits are discarded.
- ERR:
  - q_req=0.
  - Exit to IDLE when err_clr=1 and ack_s=0; both sticky errors clear on exit.
  - err_clr in any other state clears err_mismatch only.
- Boundaries:
  - A back-to-back word may be accepted in the IDLE cycle immediately after the done pulse.
  - Ack glitches shorter than the synchronizer depth are not specified as tolerated.
  - Reset mid-word aborts the word at once: q_req drops asynchronously and no done pulse is issued.
- Per-bit latency with responder delays Dr (req→ack rise) and Df (req fall→ack fall), in cycles: 1 + Dr + SYNC_STAGES + 1 + Df + SYNC_STAGES.

Test Plan:
- Word 8'hA5, behavioral Q-flop responder (ack rises and falls 3 cycles after req, out=data):
  - q_data sequence 1,0,1,0,0,1,0,1; exactly 8 q_req pulses.
  - One done pulse; err_mismatch=0; in_ready=0 throughout.
- Back-to-back words 8'hFF then 8'h00 with in_valid held high:
  - Second word accepted the cycle after done; 16 handshakes total, no bit lost.
- Responder forces out=0 on bit 2 of 8'h07:
  - err_mismatch=1 from that REQ exit onward; done still pulses.
  - err_clr pulse returns err_mismatch to 0.
- Responder never acks, TIMEOUT=15:
  - q_req drops and err_timeout=1 after 15 cycles in REQ; state ERR; in_ready=0.
  - err_clr with ack low returns to IDLE, in_ready=1.
- rst=0 asserted mid-word (bit 4, q_req=1):
  - q_req, q_data and all flags go to 0 immediately, with no clock edge needed.
  - After release, a new word 8'h3C transmits correctly.
- in_valid pulsed while busy:
  - Word not accepted; shift contents unchanged.
